// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Writer side of the instruction-memory interface. Receives a
//                length-prefixed byte stream over valid/ready, packs the
//                bytes little-endian into 32-bit words and issues one write
//                strobe per word at consecutive word-aligned byte addresses.
//                busy stays high for the whole session so that the core can
//                be held in reset until the image is complete.
//                Optional build macro IMEM_LOADER_CHECKSUM_EN adds a trailing
//                8-bit XOR checksum byte that is verified before done.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int                DEPTH_WORDS = 320,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       word_cnt
);

    // Capacity expressed in the width of the length field for the range check.
    localparam logic [15:0] c_depth_words = 16'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        S_CHK   = 3'd7
`endif
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [15:0]       r_len;        // number of words announced by the header
    logic [23:0]       r_shift;      // bytes 0..2 of the word being assembled
    logic [1:0]        r_idx;        // byte position inside the current word
    logic [15:0]       r_word_cnt;   // words written in this session
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;

    logic              w_accept;     // a byte transfers on this cycle
    logic [15:0]       w_len_full;   // length as seen while its high byte arrives
    logic              w_last_word;  // the word in WRITE completes the image
    logic [ADDR_W-1:0] w_word_addr;  // byte address of the word being assembled

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        r_xor;        // running XOR over accepted data bytes
`endif

    assign w_accept    = byte_valid & byte_ready;
    assign w_len_full  = {byte_in, r_len[7:0]};
    assign w_last_word = ((r_word_cnt + 16'd1) == r_len);
    // Address arithmetic wraps naturally at ADDR_W bits.
    assign w_word_addr = BASE_ADDR + ADDR_W'({r_word_cnt, 2'b00});

    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign word_cnt = r_word_cnt;

    // State register; reset wins over every other event.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-state handshake/status outputs.
    always_comb begin
        w_state_next = r_state;
        byte_ready   = 1'b0;
        wr_en        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;

        unique case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                done  = (r_state == S_DONE);
                error = (r_state == S_ERR);
                if (start) begin
                    w_state_next = S_LEN0;
                end
            end

            S_LEN0: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) begin
                    w_state_next = S_LEN1;
                end
            end

            S_LEN1: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) begin
                    if (w_len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        w_state_next = S_CHK;
`else
                        w_state_next = S_DONE;
`endif
                    end else if (w_len_full > c_depth_words) begin
                        // Oversize images are refused before any write happens.
                        w_state_next = S_ERR;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end

            S_DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid && (r_idx == 2'd3)) begin
                    w_state_next = S_WRITE;
                end
            end

            S_WRITE: begin
                wr_en = 1'b1;
                busy  = 1'b1;
                if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_state_next = S_CHK;
`else
                    w_state_next = S_DONE;
`endif
                end else begin
                    w_state_next = S_DATA;
                end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) begin
                    w_state_next = (byte_in == r_xor) ? S_DONE : S_ERR;
                end
            end
`endif

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: length capture, word packing, write address/data and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len      <= 16'd0;
            r_shift    <= 24'd0;
            r_idx      <= 2'd0;
            r_word_cnt <= 16'd0;
            r_wr_addr  <= BASE_ADDR;
            r_wr_data  <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor      <= 8'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_word_cnt <= 16'd0;
                        r_idx      <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_xor      <= 8'd0;
`endif
                    end
                end

                S_LEN0: begin
                    if (w_accept) begin
                        r_len[7:0] <= byte_in;
                    end
                end

                S_LEN1: begin
                    if (w_accept) begin
                        r_len[15:8] <= byte_in;
                    end
                end

                S_DATA: begin
                    if (w_accept) begin
                        r_idx <= r_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_xor <= r_xor ^ byte_in;
`endif
                        case (r_idx)
                            2'd0:    r_shift[7:0]   <= byte_in;
                            2'd1:    r_shift[15:8]  <= byte_in;
                            2'd2:    r_shift[23:16] <= byte_in;
                            default: begin
                                // Fourth byte: the word is complete, present
                                // it on the write port during the WRITE cycle.
                                r_wr_data <= {byte_in, r_shift};
                                r_wr_addr <= w_word_addr;
                            end
                        endcase
                    end
                end

                S_WRITE: begin
                    r_word_cnt <= r_word_cnt + 16'd1;
                end

                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. Expected word writes
//                are queued as each word is streamed and compared when the
//                loader strobes wr_en. Define IMEM_LOADER_CHECKSUM_EN for
//                both bench and design to exercise the checksum build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int          DEPTH_WORDS = 320;
    localparam int          ADDR_W      = 32;
    localparam logic [31:0] BASE        = 32'h0;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;
    logic              error;
    logic [15:0]       word_cnt;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];     // {addr, data} of writes still expected
    logic [31:0] words_q[$];   // image for the next load

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  chk_flip = 8'h00;
`endif

    imem_loader #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then score any write strobe against the queue.
    task automatic tick();
        logic [63:0] e;
        @(posedge clk);
        #1;
        if (wr_en !== 1'b0) begin
            check("ready_low_in_write", 64'(byte_ready), 64'd0);
            check("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(wr_addr), {32'd0, e[63:32]});
                check("wr_data", 64'(wr_data), {32'd0, e[31:0]});
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bp);
        bit acc;
        acc = 1'b0;
        if (bp) begin
            repeat ($urandom_range(0, 2)) begin
                byte_valid = 1'b0;
                byte_in    = 8'($urandom);
                tick();
            end
        end
        byte_in    = b;
        byte_valid = 1'b1;
        for (int t = 0; t < 20 && !acc; t++) begin
            acc = byte_ready;
            tick();
        end
        byte_valid = 1'b0;
        if (!acc) check("accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 20 && busy; t++) tick();
        check("busy_falls", 64'(busy), 64'd0);
    endtask

    // Stream the image in words_q and queue the writes it should produce.
    task automatic do_load(input bit bp);
        logic [15:0] len;
        logic [31:0] w;
        logic [7:0]  x;
        len = 16'(words_q.size());
        x   = 8'h00;
        pulse_start();
        send_byte(len[7:0], bp);
        send_byte(len[15:8], bp);
        for (int i = 0; i < words_q.size(); i++) begin
            w = words_q[i];
            exp_q.push_back({BASE + 32'(4 * i), w});
            for (int k = 0; k < 4; k++) begin
                x = x ^ w[8*k +: 8];
                send_byte(w[8*k +: 8], bp);
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(x ^ chk_flip, bp);
`endif
        wait_idle();
        if (x == 8'hxx) check("xor_unknown", 64'(x), 64'd0);
    endtask

    task automatic end_checks(input bit exp_done, input int exp_cnt);
        check("done", 64'(done), 64'(exp_done));
        check("error", 64'(error), 64'(!exp_done));
        check("busy", 64'(busy), 64'd0);
        check("ready_idle", 64'(byte_ready), 64'd0);
        check("word_cnt", 64'(word_cnt), 64'(exp_cnt));
        check("writes_outstanding", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;

        // Reset state
        tick();
        tick();
        check("rst_ready", 64'(byte_ready), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'(BASE));
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_word_cnt", 64'(word_cnt), 64'd0);
        reset = 1'b0;
        tick();

        // Basic two-word load
        words_q = '{32'h0000_0013, 32'h0010_0093};
        do_load(1'b0);
        end_checks(1'b1, 2);

        // Same image with random valid gaps
        do_load(1'b1);
        end_checks(1'b1, 2);

        // Oversize length is refused without writes
        pulse_start();
        send_byte(8'h41, 1'b0);
        send_byte(8'h01, 1'b0);
        check("ovs_error", 64'(error), 64'd1);
        check("ovs_done", 64'(done), 64'd0);
        check("ovs_busy", 64'(busy), 64'd0);
        byte_in    = 8'h5a;
        byte_valid = 1'b1;
        repeat (5) tick();
        check("ovs_ready", 64'(byte_ready), 64'd0);
        byte_valid = 1'b0;
        check("ovs_word_cnt", 64'(word_cnt), 64'd0);

        // Zero length
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 1'b0);
`endif
        wait_idle();
        end_checks(1'b1, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Zero length with a wrong checksum byte
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        wait_idle();
        end_checks(1'b0, 0);

        // Checksum mismatch after a full image
        chk_flip = 8'h01;
        do_load(1'b0);
        end_checks(1'b0, 2);
        chk_flip = 8'h00;
`endif

        // Reset after the second data byte abandons the session
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h00, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_word_cnt", 64'(word_cnt), 64'd0);
        check("mid_rst_ready", 64'(byte_ready), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        tick();
        do_load(1'b0);
        end_checks(1'b1, 2);

        // Largest image that fits
        words_q.delete();
        for (int i = 0; i < DEPTH_WORDS; i++) words_q.push_back($urandom);
        do_load(1'b0);
        end_checks(1'b1, DEPTH_WORDS);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
